clock_mode_ctrl: RTL and testbench
==================================

// Module: clock_mode_ctrl
// PURPOSE
//  Mode/sequencing controller for the HH:MM clock datapath.
//  - Owns the 1 Hz timebase.
//  - Decides when the time registers count, when the user edits hours or minutes, and which
//    seven-segment digits blink during edit.
//  - Sits between the debounced buttons and the time counter / SS_Driver; it does not store time itself.
// PARAMETERS
//  TICK_DIV      100000000  clock cycles per second tick (>=2)
//  BLINK_DIV     50000000   cycles per blink half-period in edit modes (>=1)
//  EDIT_TIMEOUT  10         idle seconds in an edit mode before auto-return to RUN (>=1)
//  REPEAT_DLY    50000000   hold cycles before auto-repeat starts (HOLD_REPEAT_EN only)
//  REPEAT_RATE   20000000   cycles between auto-repeat increments (HOLD_REPEAT_EN only)
// PORTS
//  CLK100MHZ     in   1  system clock
//  reset         in   1  asynchronous, active-high reset
//  btn_mode      in   1  debounced single-cycle pulse: advance mode
//  btn_up        in   1  debounced single-cycle pulse: increment field being edited
//  btn_up_level  in   1  debounced level of the up button (repeat only)
//  sec_tick      out  1  one-cycle pulse, once per second, RUN mode only
//  inc_hour      out  1  one-cycle pulse: time counter adds one hour
//  inc_min       out  1  one-cycle pulse: time counter adds one minute
//  clr_secs      out  1  one-cycle pulse: time counter zeroes seconds
//  mode          out  2  0=RUN, 1=SET_HR, 2=SET_MIN (3 never driven)
//  blank_mask    out  4  per-digit blank to SS_Driver; bit3=hours2, bit2=hours1, bit1=mins2, bit0=mins1
// BEHAVIOUR
//  Reset
//  - All outputs are registered.
//  - Reset forces: mode=RUN; sec_tick, inc_hour, inc_min, clr_secs = 0; blank_mask=0.
//  - Reset clears all counters (prescaler, blink, timeout, repeat) and the blink phase.
//  Prescaler
//  - Counts 0..TICK_DIV-1 and wraps.
//  - Internal strobe fires on the wrap, so the first strobe occurs TICK_DIV cycles after reset release.
//  - sec_tick = strobe AND mode==RUN.
//  - Prescaler is cleared to 0 on every entry to RUN.
//  FSM transitions
//  - RUN     -btn_mode-> SET_HR
//  - SET_HR  -btn_mode-> SET_MIN
//  - SET_MIN -btn_mode-> RUN
//  - SET_HR / SET_MIN -timeout-> RUN
//  Every entry to RUN
//  - Emits one clr_secs pulse.
//  - Clears the prescaler, so the next sec_tick arrives TICK_DIV cycles later.
//  Increments and latency
//  - btn_up in SET_HR gives inc_hour; btn_up in SET_MIN gives inc_min; btn_up in RUN is ignored.
//  - Latency is 1 cycle from input pulse to output pulse.
//  - Increments are never merged or dropped.
//  Simultaneous events
//  - btn_mode and btn_up in the same cycle: mode change wins, btn_up is discarded.
//  - btn_mode and timeout in the same cycle: timeout wins, FSM goes to RUN.
//  Timeout
//  - Idle-second counter runs only in edit modes and counts strobes.
//  - Cleared on any btn_mode, btn_up, repeat increment, or mode change.
//  - Reaching EDIT_TIMEOUT gives mode=RUN on the next cycle.
//  Blink
//  - Phase toggles every BLINK_DIV cycles in edit modes.
//  - Phase is reset to visible (0) and its counter cleared on edit-mode entry and on every increment.
//  - SET_HR: blank_mask = {ph,ph,0,0}.
//  - SET_MIN: blank_mask = {0,0,ph,ph}.
//  - RUN: blank_mask = 0.
//  Widths and mid-operation reset
//  - Counter widths are $clog2 of their terminal value.
//  - No counter overflows; all wrap or saturate at their terminal value.
//  - Reset mid-edit is asynchronous: mode and blank_mask go to 0 without waiting for a clock edge.
// CONFIGURATION
//  HOLD_REPEAT_EN defined
//  - In an edit mode, btn_up_level held high for REPEAT_DLY cycles, counted from the btn_up pulse,
//    produces one increment.
//  - Further increments follow every REPEAT_RATE cycles while the level stays high.
//  - Repeat stops on release or on a mode change.
//  - Repeat increments obey the same latency, blink and timeout rules as btn_up.
//  HOLD_REPEAT_EN undefined
//  - btn_up_level is ignored and no repeat logic is built.
//  - Only btn_up pulses increment.
// TESTING  (TICK_DIV=10, BLINK_DIV=4, EDIT_TIMEOUT=3, REPEAT_DLY=6, REPEAT_RATE=3)
//  1. Release reset, idle 35 cycles
//     -> sec_tick high at cycles 10, 20, 30 only; inc_*, clr_secs, mode, blank_mask all 0.
//  2. btn_mode pulse, then idle 12 cycles
//     -> mode=1 next cycle; blank_mask 0000 for 4 cycles, 1100 for 4 cycles, 0000 after that;
//        sec_tick stays 0.
//  3. In SET_HR, 3 separated btn_up pulses
//     -> 3 inc_hour pulses, each 1 cycle after its input; inc_min=0; blank_mask 0000 after each.
//  4. In SET_HR, btn_mode and btn_up in the same cycle
//     -> mode=2; no inc_hour and no inc_min pulse.
//  5. In SET_MIN, idle 30 cycles
//     -> mode=0 and a single clr_secs pulse; next sec_tick exactly 10 cycles later.
//     Then assert reset mid-SET_HR -> mode=0 and blank_mask=0 before the next edge.
//  6. HOLD_REPEAT_EN, SET_MIN, btn_up pulse then btn_up_level held 15 cycles
//     -> inc_min at +1, +7, +10, +13, +16 (first from pulse, then REPEAT_DLY, then every REPEAT_RATE);
//     without the macro -> only the +1 pulse.

Source files
------------

// File: rtl/clock_mode_ctrl_if.sv
// Button pulses in, time-counter strobes and display controls out, for the HH:MM mode controller.
// The master side drives the debounced buttons; the slave side is the controller itself.
interface clock_mode_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_up_level;
  logic       sec_tick;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_secs;
  logic [1:0] mode;
  logic [3:0] blank_mask;

  modport master (
    output btn_mode, btn_up, btn_up_level,
    input  sec_tick, inc_hour, inc_min, clr_secs, mode, blank_mask
  );

  modport slave (
    input  btn_mode, btn_up, btn_up_level,
    output sec_tick, inc_hour, inc_min, clr_secs, mode, blank_mask
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// HH:MM clock mode controller: 1 Hz timebase, RUN/SET_HR/SET_MIN sequencing, edit blink, edit timeout.
// Button to increment latency 1 cycle, no backpressure (pulses never dropped); HOLD_REPEAT_EN adds hold-to-repeat.
module clock_mode_ctrl #(
  parameter int TICK_DIV     = 100000000,
  parameter int BLINK_DIV    = 50000000,
  parameter int EDIT_TIMEOUT = 10,
  parameter int REPEAT_DLY   = 50000000,
  parameter int REPEAT_RATE  = 20000000
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  clock_mode_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (EDIT_TIMEOUT > 1) ? $clog2(EDIT_TIMEOUT) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(EDIT_TIMEOUT - 1);

  mode_e         mode_q, mode_d;
  logic [PW-1:0] pre_cnt, pre_cnt_d;
  logic [BW-1:0] blink_cnt, blink_cnt_d;
  logic          blink_ph, blink_ph_d;
  logic [IW-1:0] idle_cnt, idle_cnt_d;

  logic          strobe, edit, inc_evt, timeout, mode_chg, to_run, rep_fire;
  logic          sec_tick_q, inc_hour_q, inc_min_q, clr_secs_q;
  logic [3:0]    blank_mask_q, blank_mask_d;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      mode_q <= RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    strobe   = (pre_cnt == PRE_LAST);
    edit     = (mode_q != RUN);
    // btn_mode swallows a coincident increment; an increment counts as activity and holds off the timeout
    inc_evt  = edit && !bus.btn_mode && (bus.btn_up || rep_fire);
    timeout  = edit && strobe && (idle_cnt == IDLE_LAST) && !inc_evt;

    mode_d = mode_q;
    if (timeout) begin
      mode_d = RUN;
    end else if (bus.btn_mode) begin
      case (mode_q)
        RUN:     mode_d = SET_HR;
        SET_HR:  mode_d = SET_MIN;
        default: mode_d = RUN;
      endcase
    end
    mode_chg = (mode_d != mode_q);
    to_run   = mode_chg && (mode_d == RUN);

    pre_cnt_d = (to_run || strobe) ? '0 : pre_cnt + PW'(1);

    blink_cnt_d = blink_cnt + BW'(1);
    blink_ph_d  = blink_ph;
    if (mode_d == RUN || mode_chg || inc_evt) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph;
    end

    idle_cnt_d = idle_cnt;
    if (!edit || mode_chg || inc_evt || bus.btn_mode || bus.btn_up) begin
      idle_cnt_d = '0;
    end else if (strobe && idle_cnt != IDLE_LAST) begin
      idle_cnt_d = idle_cnt + IW'(1);
    end

    blank_mask_d = 4'b0000;
    case (mode_d)
      SET_HR:  blank_mask_d = {blink_ph_d, blink_ph_d, 2'b00};
      SET_MIN: blank_mask_d = {2'b00, blink_ph_d, blink_ph_d};
      default: blank_mask_d = 4'b0000;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      pre_cnt      <= '0;
      blink_cnt    <= '0;
      blink_ph     <= 1'b0;
      idle_cnt     <= '0;
      sec_tick_q   <= 1'b0;
      inc_hour_q   <= 1'b0;
      inc_min_q    <= 1'b0;
      clr_secs_q   <= 1'b0;
      blank_mask_q <= 4'b0000;
    end else begin
      pre_cnt      <= pre_cnt_d;
      blink_cnt    <= blink_cnt_d;
      blink_ph     <= blink_ph_d;
      idle_cnt     <= idle_cnt_d;
      sec_tick_q   <= strobe && (mode_q == RUN);
      inc_hour_q   <= inc_evt && (mode_q == SET_HR);
      inc_min_q    <= inc_evt && (mode_q == SET_MIN);
      clr_secs_q   <= to_run;
      blank_mask_q <= blank_mask_d;
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rep_cnt, rep_cnt_d;
  logic          rep_act, rep_act_d, rep_first, rep_first_d;

  assign rep_fire = rep_act && edit && bus.btn_up_level &&
                    (rep_cnt == (rep_first ? DLY_LAST : RATE_LAST));

  always_comb begin
    rep_act_d   = rep_act;
    rep_first_d = rep_first;
    rep_cnt_d   = rep_cnt + RW'(1);
    if (mode_chg) begin
      rep_act_d = 1'b0;
      rep_cnt_d = '0;
    end else if (edit && bus.btn_up) begin
      // the hold delay is measured from the press pulse itself
      rep_act_d   = 1'b1;
      rep_first_d = 1'b1;
      rep_cnt_d   = '0;
    end else if (!rep_act || !bus.btn_up_level) begin
      rep_act_d = 1'b0;
      rep_cnt_d = '0;
    end else if (rep_fire) begin
      rep_first_d = 1'b0;
      rep_cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_act   <= 1'b0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_d;
      rep_act   <= rep_act_d;
      rep_first <= rep_first_d;
    end
  end
`else
  logic unused_level;
  assign unused_level = bus.btn_up_level;
  assign rep_fire     = 1'b0;
`endif

  assign bus.sec_tick   = sec_tick_q;
  assign bus.inc_hour   = inc_hour_q;
  assign bus.inc_min    = inc_min_q;
  assign bus.clr_secs   = clr_secs_q;
  assign bus.mode       = mode_q;
  assign bus.blank_mask = blank_mask_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with a small timebase; expectations follow HOLD_REPEAT_EN when defined.
module tb_clock_mode_ctrl;
  logic CLK100MHZ = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(
    .TICK_DIV(10), .BLINK_DIV(4), .EDIT_TIMEOUT(3), .REPEAT_DLY(6), .REPEAT_RATE(3)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // {len cycles, btn_mode, btn_up, expected {sec_tick, inc_hour, inc_min, clr_secs, mode, blank_mask}}
  typedef struct {
    int         len;
    logic       bm;
    logic       bu;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int len, logic bm, logic bu, logic tk, logic hr, logic mn,
                              logic clr, logic [1:0] md, logic [3:0] msk);
    vec_t v;
    v.len = len;
    v.bm  = bm;
    v.bu  = bu;
    v.exp = {tk, hr, mn, clr, md, msk};
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {bus.sec_tick, bus.inc_hour, bus.inc_min, bus.clr_secs, bus.mode, bus.blank_mask};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_rep;

    //            len bm bu tk hr mn clr md     mask
    vecs.push_back(mk(9, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0));   // edges 1..9
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2'd0, 4'h0));   // 10
    vecs.push_back(mk(9, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2'd0, 4'h0));   // 20
    vecs.push_back(mk(9, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2'd0, 4'h0));   // 30
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0));   // 31..35
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 2'd1, 4'h0));   // 36 enter SET_HR
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 2'd1, 4'h0));
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 2'd1, 4'hC));   // 40..43, strobe at 40 gated
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 2'd1, 4'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'd1, 4'hC));   // 48
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 2'd1, 4'h0));   // 49 inc resets blink
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'd1, 4'h0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 2'd1, 4'h0));   // 51
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'd1, 4'h0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 2'd1, 4'h0));   // 53
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 2'd1, 4'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'd1, 4'hC));   // 57
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2'd2, 4'h0));   // 58 mode wins over up
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 2'd2, 4'h0));   // 59 inc_min
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 2'd2, 4'h0));
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 2'd2, 4'h3));   // 63..66
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 2'd2, 4'h0));
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 2'd2, 4'h3));
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 2'd2, 4'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'd2, 4'h3));   // 79
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2'd0, 4'h0));   // 80 timeout, clr_secs
    vecs.push_back(mk(9, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2'd0, 4'h0));   // 90 tick 10 after RUN entry

    reset            = 1'b1;
    bus.btn_mode     = 1'b0;
    bus.btn_up       = 1'b0;
    bus.btn_up_level = 1'b0;
    repeat (3) tick();
    check("reset_state", 32'(outs()), 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].len; c++) begin
        bus.btn_mode = (c == 0) ? vecs[i].bm : 1'b0;
        bus.btn_up   = (c == 0) ? vecs[i].bu : 1'b0;
        tick();
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        check($sformatf("vec%0d_cyc%0d", i, c), 32'(outs()), 32'(vecs[i].exp));
      end
    end

    // asynchronous reset while SET_HR digits are blanked
    bus.btn_mode = 1'b1;
    tick();
    bus.btn_mode = 1'b0;
    check("hr_entry_mode", 32'(bus.mode), 32'd1);
    repeat (4) tick();
    check("pre_reset_mask", 32'(bus.blank_mask), 32'hC);
    #2 reset = 1'b1;
    #1;
    check("async_reset_mode_mask", 32'({bus.mode, bus.blank_mask}), 32'h0);
    tick();
    reset = 1'b0;

    // hold-to-repeat in SET_MIN
    bus.btn_mode = 1'b1;
    tick();
    check("rep_set_hr", 32'(bus.mode), 32'd1);
    tick();
    bus.btn_mode = 1'b0;
    check("rep_set_min", 32'(bus.mode), 32'd2);
    bus.btn_up       = 1'b1;
    bus.btn_up_level = 1'b1;
    tick();
    bus.btn_up = 1'b0;
    check("rep_first_inc", 32'({bus.inc_hour, bus.inc_min}), 32'h1);
    for (int k = 1; k <= 19; k++) begin
      bus.btn_up_level = (k <= 15);
`ifdef HOLD_REPEAT_EN
      exp_rep = (k == 6) || (k == 9) || (k == 12) || (k == 15);
`else
      exp_rep = 1'b0;
`endif
      tick();
      check($sformatf("rep_inc_plus%0d", k + 1), 32'({bus.inc_hour, bus.inc_min}), 32'({1'b0, exp_rep}));
    end
    bus.btn_up_level = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
